// File: rtl/wb_spi_slave_if.sv
// Wishbone register-port bundle for wb_spi_slave.
// Signals: cyc_i/stb_i/we_i bus handshake, adr_i word address, dat_i write data,
// sel_i byte selects, ack_o single-cycle acknowledge, dat_o read data.
// The _i/_o affixes name direction as seen from the slave.
interface wb_spi_slave_if;
  logic        cyc_i;
  logic        stb_i;
  logic [1:0]  adr_i;
  logic        we_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        ack_o;
  logic [31:0] dat_o;

  modport master (
    output cyc_i, stb_i, adr_i, we_i, dat_i, sel_i,
    input  ack_o, dat_o
  );

  modport slave (
    input  cyc_i, stb_i, adr_i, we_i, dat_i, sel_i,
    output ack_o, dat_o
  );
endinterface

// File: rtl/wb_spi_slave.sv
// SPI mode-0 target with a Wishbone register port and byte-wide TX/RX FIFOs.
// An external master drives sck/ss/mosi; TX FIFO bytes are shifted out on miso
// MSB-first and completed mosi bytes are pushed into the RX FIFO.
// Ports:
//   clk_i, rst_ni   system clock, synchronous active-low reset
//   bus             Wishbone slave (DATA at adr_i[0]=0, STATUS/CTRL at adr_i[0]=1)
//   sck, ss, mosi   asynchronous SPI inputs (ss active low)
//   miso, miso_oe   SPI output and its enable (high while selected)
// Registers (byte lane [31:24]):
//   DATA   write pushes TX FIFO, read pops RX FIFO (first-word fall-through)
//   STATUS {3'b0, ss_act, tx_udr, rx_ovf, tx_full, rx_empty}
//   CTRL   bit 26 clears rx_ovf, bit 27 clears tx_udr
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module wb_spi_slave #(
  parameter int         FIFO_DEPTH = 64,
  parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  wb_spi_slave_if.slave   bus,
  input  logic            sck,
  input  logic            ss,
  input  logic            mosi,
  output logic            miso,
  output logic            miso_oe
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Synchronizers: bit 0/1 are the 2-FF synchronizer, bit 2 is the edge-detect stage.
  logic [2:0]    sck_sync_r;
  logic [2:0]    ss_sync_r;
  logic [2:0]    mosi_sync_r;
  logic [1:0]    vld_r;
  logic          armed_r;

  logic          sck_rise_s, sck_fall_s, ss_rise_s, ss_fall_s, mosi_s;

  state_e        state_r;
  logic [7:0]    sh_tx_r;
  logic [7:0]    sh_rx_r;
  logic [2:0]    bit_cnt_r;
  logic          load_pend_r;
  logic          miso_oe_r;

  logic          tx_load_s, rx_done_s;
  logic [7:0]    tx_next_s, rx_byte_s;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
  logic [CW-1:0] tx_cnt_r, rx_cnt_r;
  logic          tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic          tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;

  logic          ack_r;
  logic [31:0]   dat_r;
  logic          rx_pop_ok_r;
  logic          bus_ack_s, wr_data_s, rd_data_s, wr_ctrl_s;
  logic [7:0]    status_s;
  logic          rx_ovf_r, tx_udr_r;
  logic          unused_s;

  assign sck_rise_s =  sck_sync_r[1] & ~sck_sync_r[2];
  assign sck_fall_s = ~sck_sync_r[1] &  sck_sync_r[2];
  assign ss_rise_s  =  ss_sync_r[1]  & ~ss_sync_r[2];
  assign ss_fall_s  = ~ss_sync_r[1]  &  ss_sync_r[2];
  assign mosi_s     =  mosi_sync_r[1];

  assign tx_empty_s = (tx_cnt_r == CW'(0));
  assign tx_full_s  = (tx_cnt_r == CW'(FIFO_DEPTH));
  assign rx_empty_s = (rx_cnt_r == CW'(0));
  assign rx_full_s  = (rx_cnt_r == CW'(FIFO_DEPTH));

  // Bus side effects only happen in the acknowledge cycle.
  assign bus_ack_s = ack_r & bus.stb_i;
  assign wr_data_s = bus_ack_s &  bus.we_i & ~bus.adr_i[0];
  assign rd_data_s = bus_ack_s & ~bus.we_i & ~bus.adr_i[0];
  assign wr_ctrl_s = bus_ack_s &  bus.we_i &  bus.adr_i[0];

  assign tx_push_s = wr_data_s & ~tx_full_s;
  assign tx_pop_s  = tx_load_s & ~tx_empty_s;
  assign rx_push_s = rx_done_s & ~rx_full_s;
  assign rx_pop_s  = rd_data_s & rx_pop_ok_r;

  assign status_s = {3'b000, (state_r == ST_ACTIVE), tx_udr_r, rx_ovf_r, tx_full_s, rx_empty_s};

  assign bus.ack_o = ack_r;
  assign bus.dat_o = dat_r;
  assign miso      = sh_tx_r[7];
  assign miso_oe   = miso_oe_r;

  assign unused_s = ^{bus.cyc_i, bus.sel_i, bus.adr_i[1], bus.dat_i[23:0]};

  // Input synchronizers plus the arm flag that blocks a start until ss has been seen high after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sck_sync_r  <= 3'b000;
      ss_sync_r   <= 3'b111;
      mosi_sync_r <= 3'b000;
      vld_r       <= 2'd0;
      armed_r     <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], sck};
      ss_sync_r   <= {ss_sync_r[1:0], ss};
      mosi_sync_r <= {mosi_sync_r[1:0], mosi};
      // vld_r reaching 3 means the synchronizer holds real samples, not reset values.
      vld_r       <= (vld_r == 2'd3) ? vld_r : vld_r + 2'd1;
      armed_r     <= armed_r | ((vld_r == 2'd3) & ss_sync_r[1]);
    end
  end

  // Per-cycle SPI events: when to fetch a TX byte and when an RX byte completes.
  always_comb begin
    tx_load_s = 1'b0;
    rx_done_s = 1'b0;
    rx_byte_s = {sh_rx_r[6:0], mosi_s};
    tx_next_s = tx_empty_s ? FILL_BYTE : tx_mem[tx_rd_ptr_r];
    case (state_r)
      ST_IDLE: begin
        tx_load_s = ss_fall_s & armed_r;
      end
      ST_ACTIVE: begin
        // ss rising suppresses any same-cycle sck action.
        tx_load_s = ~ss_rise_s & sck_fall_s & load_pend_r;
        rx_done_s = ~ss_rise_s & sck_rise_s & (bit_cnt_r == 3'd7);
      end
      default: begin
        tx_load_s = 1'b0;
        rx_done_s = 1'b0;
      end
    endcase
  end

  // SPI transfer state machine; miso is sh_tx_r[7] straight from this register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      sh_tx_r     <= 8'hFF;
      sh_rx_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      load_pend_r <= 1'b0;
      miso_oe_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (tx_load_s) begin
            state_r     <= ST_ACTIVE;
            sh_tx_r     <= tx_next_s;
            sh_rx_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            load_pend_r <= 1'b0;
            miso_oe_r   <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise_s) begin
            // Partial RX byte and any loaded TX byte are simply dropped.
            state_r     <= ST_IDLE;
            sh_tx_r     <= 8'hFF;
            bit_cnt_r   <= 3'd0;
            load_pend_r <= 1'b0;
            miso_oe_r   <= 1'b0;
          end else if (sck_rise_s) begin
            sh_rx_r <= rx_byte_s;
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r   <= 3'd0;
              load_pend_r <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else if (sck_fall_s) begin
            if (load_pend_r) begin
              sh_tx_r     <= tx_next_s;
              load_pend_r <= 1'b0;
            end else begin
              sh_tx_r <= {sh_tx_r[6:0], 1'b0};
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Wishbone acknowledge and read data, captured in the request cycle so dat_o is valid during ack.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ack_r       <= 1'b0;
      dat_r       <= 32'h0000_0000;
      rx_pop_ok_r <= 1'b0;
    end else begin
      ack_r <= bus.stb_i & ~ack_r;
      if (bus.stb_i & ~ack_r) begin
        dat_r       <= {(bus.adr_i[0] ? status_s : rx_mem[rx_rd_ptr_r]), 24'h00_0000};
        // Only the bus pops RX, so non-empty now means non-empty at ack.
        rx_pop_ok_r <= ~bus.we_i & ~bus.adr_i[0] & ~rx_empty_s;
      end
    end
  end

  // Sticky error flags; a same-cycle set beats a CTRL clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_ovf_r <= 1'b0;
      tx_udr_r <= 1'b0;
    end else begin
      rx_ovf_r <= (rx_done_s & rx_full_s)  | (rx_ovf_r & ~(wr_ctrl_s & bus.dat_i[26]));
      tx_udr_r <= (tx_load_s & tx_empty_s) | (tx_udr_r & ~(wr_ctrl_s & bus.dat_i[27]));
    end
  end

  // FIFO storage writes; contents need no reset because the counts gate every read.
  always_ff @(posedge clk_i) begin
    if (tx_push_s) begin
      tx_mem[tx_wr_ptr_r] <= bus.dat_i[31:24];
    end
    if (rx_push_s) begin
      rx_mem[rx_wr_ptr_r] <= rx_byte_s;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle are both honoured.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      tx_cnt_r    <= '0;
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
      rx_cnt_r    <= '0;
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + AW'(1);
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + AW'(1);
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + AW'(1);
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + AW'(1);
      tx_cnt_r <= tx_cnt_r + CW'(tx_push_s) - CW'(tx_pop_s);
      rx_cnt_r <= rx_cnt_r + CW'(rx_push_s) - CW'(rx_pop_s);
    end
  end

endmodule
